// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU select codes, FSM
// encoding, instruction field layout and datapath defaults.
package alu_pkg;

  localparam int DATA_W  = 4;
  localparam int NREGS   = 4;
  localparam int REG_AW  = 2;
  localparam int INSTR_W = 14;

  localparam int OP_LSB     = 10;
  localparam int OP_W       = 4;
  localparam int RD_LSB     = 8;
  localparam int RS_LSB     = 6;
  localparam int IMM_EN_BIT = 5;
  localparam int RSVD_BIT   = 4;
  localparam int IMM_LSB    = 0;
  localparam int RT_LSB     = 0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_MUL  = 4'b0010,
    ALU_DIV  = 4'b0011,
    ALU_SHL  = 4'b0100,
    ALU_SHR  = 4'b0101,
    ALU_ROL  = 4'b0110,
    ALU_ROR  = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_NOR  = 4'b1011,
    ALU_NAND = 4'b1100,
    ALU_XNOR = 4'b1101,
    ALU_GT   = 4'b1110,
    ALU_EQ   = 4'b1111
  } alu_sel_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_OPERAND   = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_e;

  function automatic logic is_div_by_zero(input logic [OP_W-1:0] sel,
                                          input logic [DATA_W-1:0] b);
    return (sel == ALU_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: async-cleared flops, one write port and three
// combinational read ports (rs, rt, debug). Reads return the pre-write value.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int RF_DATA_W = DATA_W,
  parameter int RF_NREGS  = NREGS,
  parameter int RF_AW     = REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [RF_AW-1:0]     waddr_i,
  input  logic [RF_DATA_W-1:0] wdata_i,
  input  logic [RF_AW-1:0]     raddr_rs_i,
  output logic [RF_DATA_W-1:0] rdata_rs_o,
  input  logic [RF_AW-1:0]     raddr_rt_i,
  output logic [RF_DATA_W-1:0] rdata_rt_o,
  input  logic [RF_AW-1:0]     raddr_dbg_i,
  output logic [RF_DATA_W-1:0] rdata_dbg_o
);

  logic [RF_DATA_W-1:0] mem_q [RF_NREGS];

  // NOTE: this storage is small flops, not a RAM macro, so it is cleared by
  // reset; a dropped instruction must leave every register at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_rs_o  = mem_q[raddr_rs_i];
  assign rdata_rt_o  = mem_q[raddr_rt_i];
  assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue/writeback sequencer around the combinational 4-bit ALU.
// Optional divide-by-zero trap: define ALU_ISSUE_DIV0_TRAP_EN.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_carry,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               carry_flag,
  output logic               busy,
  output logic               trap,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [REG_AW-1:0]   rs_q, rs_d;
  logic                imm_en_q, imm_en_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
  logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                carry_q, carry_d;

  logic [DATA_W-1:0]   rf_rs_data, rf_rt_data;
  logic                div0;
  logic                wb_fire;
  logic                unused_rsvd;

  // The reserved instruction bit carries no meaning.
  assign unused_rsvd = instr[RSVD_BIT];

  alu_regfile u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (wb_fire),
    .waddr_i     (wb_addr_q),
    .wdata_i     (wb_data_q),
    .raddr_rs_i  (rs_q),
    .rdata_rs_o  (rf_rs_data),
    .raddr_rt_i  (imm_q[RT_LSB +: REG_AW]),
    .rdata_rt_o  (rf_rt_data),
    .raddr_dbg_i (dbg_addr),
    .rdata_dbg_o (dbg_data)
  );

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign div0 = is_div_by_zero(alu_sel_q, alu_b_q);
`else
  assign div0 = 1'b0;
`endif

  assign wb_fire = (state_q == S_WRITEBACK) && !div0;

  // NOTE: combinational next-state logic uses blocking assignments with every
  // target defaulted first, so no latch can be inferred; only the flop
  // process below uses non-blocking assignments.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    imm_en_d  = imm_en_q;
    imm_d     = imm_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    carry_d   = carry_q;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d     = instr[OP_LSB +: OP_W];
          rd_d     = instr[RD_LSB +: REG_AW];
          rs_d     = instr[RS_LSB +: REG_AW];
          imm_en_d = instr[IMM_EN_BIT];
          imm_d    = instr[IMM_LSB +: DATA_W];
          state_d  = S_OPERAND;
        end
      end
      S_OPERAND: begin
        alu_a_d   = rf_rs_data;
        alu_b_d   = imm_en_q ? imm_q : rf_rt_data;
        alu_sel_d = op_q;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        wb_data_d = alu_out;
        wb_addr_d = rd_q;
        state_d   = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // The ALU inputs are still held, so its carry is still valid here.
        if (wb_fire && (alu_sel_q == ALU_ADD)) carry_d = alu_carry;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      imm_en_q  <= imm_en_d;
      imm_q     <= imm_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      carry_q   <= carry_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign wb_valid    = wb_fire;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign carry_flag  = carry_q;
  assign trap        = (state_q == S_WRITEBACK) && div0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [13:0] instr;
  logic [3:0]  alu_a, alu_b, alu_sel, alu_out;
  logic        alu_carry;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [3:0]  wb_data;
  logic        carry_flag, busy, trap;
  logic [1:0]  dbg_addr;
  logic [3:0]  dbg_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .carry_flag  (carry_flag),
    .busy        (busy),
    .trap        (trap),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Stand-in for the downstream combinational ALU.
  function automatic logic [4:0] alu_model(input logic [3:0] sel,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [7:0] prod;
    case (sel)
      ALU_ADD: alu_model = {1'b0, a} + {1'b0, b};
      ALU_SUB: alu_model = {1'b0, a - b};
      ALU_MUL: begin prod = a * b; alu_model = {1'b0, prod[3:0]}; end
      ALU_DIV: alu_model = (b == 4'd0) ? 5'd0 : {1'b0, a / b};
      ALU_AND: alu_model = {1'b0, a & b};
      ALU_OR:  alu_model = {1'b0, a | b};
      ALU_XOR: alu_model = {1'b0, a ^ b};
      default: alu_model = 5'd0;
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_model(alu_sel, alu_a, alu_b);

  function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic imm_en,
                                     input logic [3:0] imm);
    return {op, rd, rs, imm_en, 1'b0, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rf(input string tag, input logic [1:0] addr, input logic [3:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issue one instruction from IDLE and check every cycle through writeback.
  task automatic issue(input string tag, input logic [13:0] ins,
                       input logic [3:0] ea, input logic [3:0] eb,
                       input logic ewb, input logic [1:0] erd,
                       input logic [3:0] edata, input logic etrap);
    @(negedge clk);
    check({tag, ".ready"}, instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = '1;
    check({tag, ".busy"}, busy, 1'b1);
    @(posedge clk); #1;
    check({tag, ".alu_a"}, alu_a, ea);
    check({tag, ".alu_b"}, alu_b, eb);
    check({tag, ".alu_sel"}, alu_sel, ins[13:10]);
    @(posedge clk); #1;
    check({tag, ".wb_valid"}, wb_valid, ewb);
    check({tag, ".trap"}, trap, etrap);
    if (ewb) begin
      check({tag, ".wb_addr"}, wb_addr, erd);
      check({tag, ".wb_data"}, wb_data, edata);
    end
    @(posedge clk); #1;
    check({tag, ".idle"}, instr_ready, 1'b1);
    check({tag, ".wb_off"}, wb_valid, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", instr_ready, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst.ready", instr_ready, 1'b1);
    check("post_rst.busy", busy, 1'b0);
    check("post_rst.carry", carry_flag, 1'b0);
    check("post_rst.wb_valid", wb_valid, 1'b0);
    check("post_rst.trap", trap, 1'b0);
    for (int i = 0; i < 4; i++) check_rf("post_rst.rf", 2'(i), 4'h0);

    // ADD imm: rf[1] = rf[0] + 5
    issue("add_imm", mk(ALU_ADD, 2'd1, 2'd0, 1'b1, 4'd5), 4'h0, 4'h5, 1'b1, 2'd1, 4'h5, 1'b0);
    check_rf("add_imm.rf1", 2'd1, 4'h5);
    check("add_imm.carry", carry_flag, 1'b0);

    // Load rf[2] = 0xC, then rf[3] = rf[1] + rf[2] = 0x11 -> 0x1 with carry
    issue("ld_c", mk(ALU_ADD, 2'd2, 2'd0, 1'b1, 4'hC), 4'h0, 4'hC, 1'b1, 2'd2, 4'hC, 1'b0);
    issue("add_rr", mk(ALU_ADD, 2'd3, 2'd1, 1'b0, 4'd2), 4'h5, 4'hC, 1'b1, 2'd3, 4'h1, 1'b0);
    check("add_rr.carry", carry_flag, 1'b1);
    check_rf("add_rr.rf3", 2'd3, 4'h1);

    // XOR does not touch the carry: rf[0] = 1 ^ F = E
    issue("xor", mk(ALU_XOR, 2'd0, 2'd3, 1'b1, 4'hF), 4'h1, 4'hF, 1'b1, 2'd0, 4'hE, 1'b0);
    check("xor.carry", carry_flag, 1'b1);
    check_rf("xor.rf0", 2'd0, 4'hE);

    // Back-to-back with instr_valid held: rf[2] = 5+1 = 6, then rf[3] = rf[2]+2 = 8
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(ALU_ADD, 2'd2, 2'd1, 1'b1, 4'd1);
    @(posedge clk); #1;
    check("b2b.ready_c1", instr_ready, 1'b0);
    instr = mk(ALU_ADD, 2'd3, 2'd2, 1'b1, 4'd2);
    @(posedge clk); #1;
    check("b2b.ready_c2", instr_ready, 1'b0);
    check("b2b.alu_a1", alu_a, 4'h5);
    check("b2b.alu_b1", alu_b, 4'h1);
    @(posedge clk); #1;
    check("b2b.ready_c3", instr_ready, 1'b0);
    check("b2b.wb_valid1", wb_valid, 1'b1);
    check("b2b.wb_data1", wb_data, 4'h6);
    @(posedge clk); #1;
    check("b2b.ready_c4", instr_ready, 1'b1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("b2b.accept2", busy, 1'b1);
    @(posedge clk); #1;
    check("b2b.alu_a2", alu_a, 4'h6);
    check("b2b.alu_b2", alu_b, 4'h2);
    @(posedge clk); #1;
    check("b2b.wb_valid2", wb_valid, 1'b1);
    check("b2b.wb_addr2", wb_addr, 2'd3);
    check("b2b.wb_data2", wb_data, 4'h8);
    @(posedge clk); #1;
    check_rf("b2b.rf2", 2'd2, 4'h6);
    check_rf("b2b.rf3", 2'd3, 4'h8);
    check("b2b.carry", carry_flag, 1'b0);

    // rf[1] = 5 ^ 2 = 7, then divide by an immediate zero
    issue("ld_7", mk(ALU_XOR, 2'd1, 2'd1, 1'b1, 4'd2), 4'h5, 4'h2, 1'b1, 2'd1, 4'h7, 1'b0);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    issue("div0", mk(ALU_DIV, 2'd2, 2'd1, 1'b1, 4'd0), 4'h7, 4'h0, 1'b0, 2'd2, 4'h0, 1'b1);
    check_rf("div0.rf2", 2'd2, 4'h6);
`else
    issue("div0", mk(ALU_DIV, 2'd2, 2'd1, 1'b1, 4'd0), 4'h7, 4'h0, 1'b1, 2'd2, 4'h0, 1'b0);
    check_rf("div0.rf2", 2'd2, 4'h0);
`endif
    check("div0.carry", carry_flag, 1'b0);
    issue("div", mk(ALU_DIV, 2'd2, 2'd1, 1'b1, 4'd2), 4'h7, 4'h2, 1'b1, 2'd2, 4'h3, 1'b0);
    check_rf("div.rf2", 2'd2, 4'h3);

    // Reset during EXECUTE of ADD rd=1 drops the instruction
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(ALU_ADD, 2'd1, 2'd1, 1'b1, 4'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.alu_a_pre", alu_a, 4'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.alu_a", alu_a, 4'h0);
    check("rst_mid.alu_b", alu_b, 4'h0);
    check("rst_mid.alu_sel", alu_sel, 4'h0);
    check("rst_mid.wb_data", wb_data, 4'h0);
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.ready", instr_ready, 1'b1);
    @(posedge clk); #1;
    check("rst_mid.wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.wb_after", wb_valid, 1'b0);
    check("rst_mid.ready_after", instr_ready, 1'b1);
    check_rf("rst_mid.rf1", 2'd1, 4'h0);
    check_rf("rst_mid.rf2", 2'd2, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller that sits directly upstream and downstream of the 4-bit combinational ALU. Accepts one instruction at a time over a valid/ready handshake and reads operands from a 4-entry × 4-bit register file. Drives registered A/B/select to the ALU, captures the ALU result and carry, and writes the result back. Provides the sequencing the purely combinational ALU lacks, at a fixed 4-cycle issue interval.

## Interface
- DATA_W, 4, datapath width; must match the ALU (only 4 supported)
- NREGS, 4, register file entries
- REG_AW, 2, register address width (log2 NREGS)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept; high only in IDLE
- instr  in  14  [13:10] op, [9:8] rd, [7:6] rs, [5] imm_en, [4] reserved (ignored), [3:0] imm / rt in [1:0]
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_sel  out  4  registered ALU select (= op)
- alu_out  in  4  ALU result
- alu_carry  in  1  ALU CarryOut
- wb_valid  out  1  one-cycle writeback strobe
- wb_addr  out  2  writeback register
- wb_data  out  4  writeback value
- carry_flag  out  1  sticky-until-next-ADD carry
- busy  out  1  high in any state except IDLE
- trap  out  1  divide-by-zero pulse (tied 0 when feature compiled out)
- dbg_addr  in  2  debug read address
- dbg_data  out  4  combinational regfile read of dbg_addr

## Operation
- FSM states: IDLE → OPERAND → EXECUTE → WRITEBACK → IDLE; no other transitions.
- IDLE: instr_ready=1. Handshake when instr_valid && instr_ready at a rising edge; instr is latched, and the state moves to OPERAND.
- OPERAND: reads rf[rs] and B = imm_en ? imm : rf[rt]. Registers alu_a, alu_b and alu_sel at the edge leaving the state.
- EXECUTE: the ALU settles combinationally. At the edge leaving the state, alu_out goes to wb_data and rd to wb_addr.
- WRITEBACK: wb_valid=1. At the edge leaving the state:
  - rf[rd] ← wb_data.
  - carry_flag ← alu_carry only when op=4'b0000; otherwise carry_flag holds.
- Result width: the ALU result is taken as its low 4 bits only; upper product/quotient bits are discarded.
- r0 is an ordinary register, not hardwired.
- A dbg read of a register being written in the same cycle returns the old value.
- instr_valid deasserted or changed while busy: ignored; only the latched copy is used.
- Reset (async, any state, including mid-operation):
  - FSM goes to IDLE and all registers clear to 0.
  - alu_a, alu_b, alu_sel, wb_addr, wb_data, wb_valid, carry_flag, trap all clear to 0; busy=0, instr_ready=1.
  - An in-flight instruction is dropped with no writeback.

## Timing
- Edge 0: accept. Cycle 1: OPERAND. Cycle 2: EXECUTE (ALU inputs valid). Cycle 3: WRITEBACK (wb_valid high). Edge 3: rf/carry updated. Cycle 4: IDLE, instr_ready=1.
- Issue interval is 4 cycles.
- No hazards: the next instruction's OPERAND read (cycle 5 at the earliest) sees the prior write.
- instr_ready is a registered state decode; it is never combinationally dependent on instr_valid.

## Configuration
- ALU_ISSUE_DIV0_TRAP_EN defined:
  - Applies when op=4'b0011 and the registered B=0.
  - WRITEBACK cycle asserts trap=1 for one cycle with wb_valid=0.
  - rf and carry_flag are unchanged.
- Undefined: no check is made; trap is tied 0 and alu_out is written back as presented.

## Structure
- Shared package alu_pkg contains:
  - the 4-bit ALU select constants (ADD, SUB, MUL, DIV, …, EQ)
  - the FSM state encoding
  - instr field offsets/widths
  - DATA_W/REG_AW defaults
- One sub-module, alu_regfile: NREGS×DATA_W flops with async clear, one write port and three combinational read ports (rs, rt, dbg).

## Test plan
- Reset release → instr_ready=1, busy=0, dbg_data=0 for all dbg_addr, carry_flag=0, wb_valid never pulsed.
- ADD imm: op=0000, rd=1, rs=0, imm_en=1, imm=5 → cycle 2 alu_a=0, alu_b=5; cycle 3 wb_valid=1, wb_addr=1, wb_data=5; after: rf[1]=5, carry_flag=0.
- Carry: rf[1]=5, rf[2]=0xC, ADD rd=3 rs=1 rt=2 → wb_data=0x1, carry_flag=1. A following XOR leaves carry_flag=1.
- Back-to-back: instr_valid held high with two instrs (second reads rd of first) → instr_ready low cycles 1–3, second accepted at edge 4, uses updated value.
- Div-by-zero with ALU_ISSUE_DIV0_TRAP_EN: rf[1]=7, DIV rd=2 rs=1 imm=0 → trap=1 in cycle 3, wb_valid=0, rf[2] unchanged.
- rst_n pulsed low during EXECUTE of ADD rd=1 → outputs clear immediately, no wb_valid, rf[1]=0, instr_ready=1 after release.
